ternary_memory: RTL and testbench
=================================

// Module: ternary_memory
// PURPOSE
//  Word-addressed ternary RAM on the downstream side of the CPU memory interface.
//  Serves CPU instruction fetch, load and store with a registered read.
//  A host-side loader port clears memory and streams a program in while holding the CPU off.
//  Balanced-ternary addresses are decoded to a binary array index.
// PARAMETERS
//  WORD_SIZE      9   trits per word; buses are 2*WORD_SIZE bits
//  MEM_ADDR_SIZE  4   trits per address; DEPTH = 3**MEM_ADDR_SIZE = 81 words
// PORTS
//  clock           in   1                  single clock, rising edge
//  reset           in   1                  asynchronous, active-high
//  mem_address     in   2*MEM_ADDR_SIZE    CPU balanced-ternary address
//  mem_write_data  in   2*WORD_SIZE        CPU store data
//  mem_read        in   1                  CPU read request (fetch or load)
//  mem_write       in   1                  CPU write request
//  mem_read_data   out  2*WORD_SIZE        registered read data
//  load_start      in   1                  pulse: begin clear + program load
//  load_valid      in   1                  host word valid
//  load_last       in   1                  qualifies the final host word
//  load_data       in   2*WORD_SIZE        host word
//  load_ready      out  1                  memory accepts host word this cycle
//  cpu_hold        out  1                  high while CLEAR/LOAD; gates CPU execute
//  load_done       out  1                  one-cycle pulse when LOAD completes
//  trit_error      out  1                  sticky: illegal trit code 2'b11 was written
//  protect_fault   out  1                  sticky: CPU wrote a protected word (macro only)
// BEHAVIOUR
//  Trit code: 2'b00=0, 2'b01=+1, 2'b10=-1, 2'b11 illegal.
//  - Illegal trits in any written word are stored as 2'b00; trit_error is set until reset.
//  Index = balanced value(mem_address) + (DEPTH-1)/2, so address 0 maps to index 40.
//  - Address trit 2'b11 decodes as 0.
//  Reset: mem_read_data=0, load_ready=0, cpu_hold=0, load_done=0, trit_error=0,
//   protect_fault=0, FSM=IDLE. Array contents are not reset.
//  FSM:
//  - IDLE: serve CPU.
//    - load_start -> CLEAR, clear counter=0, cpu_hold=1.
//  - CLEAR: write 0 to one index per cycle, 0..DEPTH-1 (DEPTH cycles).
//    - Then -> LOAD; load pointer = index 40 (address 0).
//  - LOAD: load_ready=1. Each load_valid cycle writes load_data at pointer, then pointer+1.
//    - Pointer wraps DEPTH-1 -> 0.
//    - load_valid && load_last -> IDLE, load_done=1 next cycle, cpu_hold=0 next cycle.
//  - Count DEPTH accepted words without load_last -> IDLE and pulse load_done (memory full).
//  - load_start outside IDLE is ignored.
//  CPU port, IDLE only:
//  - mem_read: mem_read_data <= word[index] at the next edge (latency 1); holds its value otherwise.
//  - mem_write: word[index] <= mem_write_data at the edge.
//  - mem_read && mem_write together: write wins; mem_read_data is unchanged.
//  - Outside IDLE, CPU requests are ignored and mem_read_data holds.
//  Reset mid-CLEAR or mid-LOAD: returns to IDLE, cpu_hold drops, partial contents are kept.
// CONFIGURATION
//  MEM_WRITE_PROTECT_EN defined:
//  - Indices written during LOAD are recorded (protect bit per word; cleared in CLEAR).
//  - A CPU write to a protected index is dropped and sets protect_fault.
//  MEM_WRITE_PROTECT_EN undefined:
//  - No protect bits; all CPU writes land; protect_fault is tied 0.
// STRUCTURE
//  Shared parameters.vh: WORD_SIZE, MEM_ADDR_SIZE, trit code macros, FSM state encodings.
//  Sub-module trit_addr_decoder: combinational balanced-ternary address to binary index.
//  - Instanced once for mem_address.
//  - The loader pointer is kept in binary and needs no decoder.
// TESTING
//  1 Reset mid-LOAD after 3 words -> IDLE, cpu_hold=0, load_done never pulses.
//  2 load_start, then 3 words 0x01,0x02,0x06 with load_last on the third:
//    - cpu_hold high for 81+3 cycles; load_done pulses once.
//    - CPU reads at addresses 0, +1, +2 return the 3 words one cycle after mem_read.
//    - CPU read at address -1 returns 0 (cleared).
//  3 CPU write 0x15 to address -4, read address -4 next cycle:
//    - mem_read_data = 0x15 exactly one cycle after mem_read.
//  4 mem_read && mem_write to the same address:
//    - Word updated; mem_read_data unchanged that cycle.
//  5 Write a word containing trit 2'b11, then read it back:
//    - That trit reads 2'b00; trit_error=1 and stays set until reset.
//  6 Full load, 81 words, no load_last:
//    - Pointer wraps to index 0 and write-back finishes at index 39; load_done pulses once.
//  6 (MEM_WRITE_PROTECT_EN only) CPU write to a loaded address:
//    - Readback shows the original word; protect_fault=1.

Source files
------------

// File: rtl/ternary_memory_pkg.sv
// Shared constants for the ternary RAM: word/address sizes, trit codes and
// loader FSM states. Used by ternary_memory and trit_addr_decoder.
package ternary_memory_pkg;

    localparam int WORD_SIZE     = 9;
    localparam int MEM_ADDR_SIZE = 4;
    localparam int WORD_W        = 2 * WORD_SIZE;
    localparam int ADDR_W        = 2 * MEM_ADDR_SIZE;
    localparam int DEPTH         = 3 ** MEM_ADDR_SIZE;
    localparam int IDX_W         = $clog2(DEPTH);

    // Array index of balanced address 0 and of the last word.
    localparam logic [IDX_W-1:0] MID_IDX  = IDX_W'((DEPTH - 1) / 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_NEG  = 2'b10;
    localparam logic [1:0] TRIT_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

endpackage

// File: rtl/ternary_memory_trit_addr_decoder.sv
// Combinational balanced-ternary address to binary array index.
// Trit 0 sits in the two least significant bits; the illegal code decodes as 0.
module trit_addr_decoder
    import ternary_memory_pkg::*;
(
    input  logic [ADDR_W-1:0] address,
    output logic [IDX_W-1:0]  index
);

    int signed acc;
    int signed weight;

    // Weighted sum of trits, offset so the most negative address lands on index 0.
    always_comb begin
        acc    = (DEPTH - 1) / 2;
        weight = 1;
        for (int i = 0; i < MEM_ADDR_SIZE; i++) begin
            case (address[2*i +: 2])
                TRIT_POS: acc = acc + weight;
                TRIT_NEG: acc = acc - weight;
                default:  acc = acc;
            endcase
            weight = weight * 3;
        end
        index = IDX_W'(acc);
    end

endmodule

// File: rtl/ternary_memory.sv
// Word-addressed ternary RAM with registered CPU read and a host loader that
// clears the array and streams a program in starting at address 0.
// Optional feature macro: MEM_WRITE_PROTECT_EN (CPU writes to loaded words are
// dropped and flagged on protect_fault).
module ternary_memory
    import ternary_memory_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [WORD_W-1:0] mem_write_data,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [WORD_W-1:0] mem_read_data,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic              load_last,
    input  logic [WORD_W-1:0] load_data,
    output logic              load_ready,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              trit_error,
    output logic              protect_fault
);

    state_t            state, next_state;
    logic [IDX_W-1:0]  cpu_idx;
    logic [IDX_W-1:0]  clear_cnt;
    logic [IDX_W-1:0]  load_ptr;
    logic [IDX_W-1:0]  load_cnt;
    logic [WORD_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [WORD_W-1:0] wr_raw;
    logic              load_finish;
    logic              cpu_wr_blocked;

    // Illegal trits are stored as zero.
    function automatic logic [WORD_W-1:0] sanitize(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        r = w;
        for (int i = 0; i < WORD_SIZE; i++)
            if (w[2*i +: 2] == TRIT_BAD) r[2*i +: 2] = TRIT_ZERO;
        return r;
    endfunction

    function automatic logic has_bad_trit(input logic [WORD_W-1:0] w);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < WORD_SIZE; i++)
            if (w[2*i +: 2] == TRIT_BAD) bad = 1'b1;
        return bad;
    endfunction

    trit_addr_decoder u_addr_decoder (
        .address (mem_address),
        .index   (cpu_idx)
    );

`ifdef MEM_WRITE_PROTECT_EN
    logic [DEPTH-1:0] protect;

    assign cpu_wr_blocked = protect[cpu_idx];

    // Protect bits follow the loader: cleared with the array, set per loaded word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            protect       <= '0;
            protect_fault <= 1'b0;
        end else begin
            if (state == ST_CLEAR)
                protect[clear_cnt] <= 1'b0;
            if (state == ST_LOAD && load_valid)
                protect[load_ptr] <= 1'b1;
            if (state == ST_IDLE && mem_write && cpu_wr_blocked)
                protect_fault <= 1'b1;
        end
    end
`else
    assign cpu_wr_blocked = 1'b0;
    assign protect_fault  = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next state, status outputs and the single write-port mux.
    always_comb begin
        next_state  = state;
        wr_en       = 1'b0;
        wr_idx      = cpu_idx;
        wr_raw      = '0;
        load_ready  = 1'b0;
        cpu_hold    = 1'b0;
        load_finish = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_write && !cpu_wr_blocked) begin
                    wr_en  = 1'b1;
                    wr_raw = mem_write_data;
                end
                if (load_start) next_state = ST_CLEAR;
            end
            ST_CLEAR: begin
                cpu_hold = 1'b1;
                wr_en    = 1'b1;
                wr_idx   = clear_cnt;
                if (clear_cnt == LAST_IDX) next_state = ST_LOAD;
            end
            ST_LOAD: begin
                cpu_hold   = 1'b1;
                load_ready = 1'b1;
                if (load_valid) begin
                    wr_en  = 1'b1;
                    wr_idx = load_ptr;
                    wr_raw = load_data;
                    // Stop on the host's last word or once every word has been filled.
                    if (load_last || load_cnt == LAST_IDX) begin
                        load_finish = 1'b1;
                        next_state  = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Loader counters, done pulse and sticky illegal-trit flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clear_cnt  <= '0;
            load_ptr   <= '0;
            load_cnt   <= '0;
            load_done  <= 1'b0;
            trit_error <= 1'b0;
        end else begin
            load_done <= load_finish;
            if (wr_en && has_bad_trit(wr_raw))
                trit_error <= 1'b1;
            case (state)
                ST_IDLE: clear_cnt <= '0;
                ST_CLEAR: begin
                    clear_cnt <= clear_cnt + 1'b1;
                    load_ptr  <= MID_IDX;
                    load_cnt  <= '0;
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        load_ptr <= (load_ptr == LAST_IDX) ? '0 : load_ptr + 1'b1;
                        load_cnt <= load_cnt + 1'b1;
                    end
                end
                default: clear_cnt <= '0;
            endcase
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_idx] <= sanitize(wr_raw);
    end

    // Registered CPU read; a simultaneous write takes priority and the output holds.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            mem_read_data <= '0;
        else if (state == ST_IDLE && mem_read && !mem_write)
            mem_read_data <= mem[cpu_idx];
    end

endmodule

// File: tb/tb_ternary_memory.sv
// Directed self-checking bench for ternary_memory.
module tb_ternary_memory;

    localparam int WW = 18;

    // Hand-encoded balanced-ternary addresses (trit 0 in bits [1:0]).
    localparam logic [7:0] A_0   = 8'h00;  // index 40
    localparam logic [7:0] A_P1  = 8'h01;  // +1
    localparam logic [7:0] A_P2  = 8'h06;  // +2 = +3 -1
    localparam logic [7:0] A_P3  = 8'h04;  // +3
    localparam logic [7:0] A_M1  = 8'h02;  // -1 -> index 39
    localparam logic [7:0] A_M2  = 8'h09;  // -2 = -3 +1
    localparam logic [7:0] A_M4  = 8'h0A;  // -4 = -3 -1 -> index 36
    localparam logic [7:0] A_P40 = 8'h55;  // +40 -> index 80
    localparam logic [7:0] A_M40 = 8'hAA;  // -40 -> index 0

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    mem_address = '0;
    logic [WW-1:0] mem_write_data = '0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [WW-1:0] mem_read_data;
    logic          load_start = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_last = 1'b0;
    logic [WW-1:0] load_data = '0;
    logic          load_ready;
    logic          cpu_hold;
    logic          load_done;
    logic          trit_error;
    logic          protect_fault;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int hold_cnt = 0;
    int done_base;
    int hold_base;

    ternary_memory dut (
        .clock          (clock),
        .reset          (reset),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data),
        .load_start     (load_start),
        .load_valid     (load_valid),
        .load_last      (load_last),
        .load_data      (load_data),
        .load_ready     (load_ready),
        .cpu_hold       (cpu_hold),
        .load_done      (load_done),
        .trit_error     (trit_error),
        .protect_fault  (protect_fault)
    );

    always #5 clock = ~clock;

    // Count load_done pulses and held cycles, sampled mid-cycle.
    always @(negedge clock) begin
        if (load_done) done_cnt <= done_cnt + 1;
        if (cpu_hold)  hold_cnt <= hold_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_read(input logic [7:0] addr);
        mem_address = addr;
        mem_read    = 1'b1;
        tick();
        mem_read    = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [WW-1:0] data);
        mem_address    = addr;
        mem_write_data = data;
        mem_write      = 1'b1;
        tick();
        mem_write      = 1'b0;
    endtask

    // Pulse load_start and wait (bounded) for the CLEAR phase to finish.
    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 200 && !load_ready; i++) tick();
        chk("ready_seen", load_ready, 1);
    endtask

    // Legal word built from the bits of k: each bit becomes trit 0 or +1, top trit +1.
    function automatic logic [WW-1:0] full_word(input int k);
        logic [WW-1:0] w;
        logic [31:0]   kb;
        kb = k;
        w  = 18'h10000;
        for (int b = 0; b < 7; b++) w[2*b] = kb[b];
        return w;
    endfunction

    initial begin
        // Reset state
        #1;
        chk("rst_read_data", mem_read_data, 0);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_trit_error", trit_error, 0);
        chk("rst_protect_fault", protect_fault, 0);
        tick();
        reset = 1'b0;
        tick();

        // 1: reset in the middle of LOAD
        done_base = done_cnt;
        start_load();
        for (int k = 0; k < 3; k++) begin
            load_valid = 1'b1;
            load_data  = 18'(k + 1);
            tick();
        end
        load_valid = 1'b0;
        chk("t1_hold_before_rst", cpu_hold, 1);
        reset = 1'b1;
        #1;
        chk("t1_hold_after_rst", cpu_hold, 0);
        chk("t1_ready_after_rst", load_ready, 0);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("t1_no_done", done_cnt - done_base, 0);

        // 2: short program load with load_last
        done_base = done_cnt;
        hold_base = hold_cnt;
        start_load();
        load_valid = 1'b1;
        load_data  = 18'h00001;
        tick();
        load_data  = 18'h00002;
        tick();
        load_data  = 18'h00006;
        load_last  = 1'b1;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("t2_done_pulse", load_done, 1);
        chk("t2_hold_drop", cpu_hold, 0);
        tick();
        chk("t2_done_low", load_done, 0);
        chk("t2_done_once", done_cnt - done_base, 1);
        chk("t2_hold_cycles", hold_cnt - hold_base, 84);
        cpu_read(A_0);
        chk("t2_rd_addr0", mem_read_data, 18'h00001);
        cpu_read(A_P1);
        chk("t2_rd_addr_p1", mem_read_data, 18'h00002);
        cpu_read(A_P2);
        chk("t2_rd_addr_p2", mem_read_data, 18'h00006);
        cpu_read(A_M1);
        chk("t2_rd_addr_m1", mem_read_data, 18'h00000);

        // 3: write then read, latency exactly one
        cpu_write(A_M4, 18'h00015);
        mem_address = A_M4;
        mem_read    = 1'b1;
        #1;
        chk("t3_before_edge", mem_read_data, 18'h00000);
        tick();
        mem_read    = 1'b0;
        chk("t3_rd_after_wr", mem_read_data, 18'h00015);

        // 4: read and write together: write wins, output holds
        mem_address    = A_M2;
        mem_write_data = 18'h0002A;
        mem_read       = 1'b1;
        mem_write      = 1'b1;
        tick();
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        chk("t4_rd_held", mem_read_data, 18'h00015);
        cpu_read(A_M2);
        chk("t4_word_updated", mem_read_data, 18'h0002A);

        // 5: illegal trit stored as zero, sticky error
        chk("t5_err_before", trit_error, 0);
        cpu_write(A_P3, 18'h00013);
        chk("t5_err_set", trit_error, 1);
        cpu_read(A_P3);
        chk("t5_trit_zeroed", mem_read_data, 18'h00010);
        repeat (3) tick();
        chk("t5_err_sticky", trit_error, 1);

        // 6: full load of 81 words without load_last
        done_base = done_cnt;
        start_load();
        for (int k = 0; k < 81; k++) begin
            load_valid = 1'b1;
            load_data  = full_word(k);
            tick();
        end
        load_valid = 1'b0;
        chk("t6_done_pulse", load_done, 1);
        chk("t6_ready_low", load_ready, 0);
        tick();
        chk("t6_done_once", done_cnt - done_base, 1);
        cpu_read(A_0);
        chk("t6_rd_idx40", mem_read_data, full_word(0));
        cpu_read(A_P40);
        chk("t6_rd_idx80", mem_read_data, full_word(40));
        cpu_read(A_M40);
        chk("t6_rd_idx0_wrap", mem_read_data, full_word(41));
        cpu_read(A_M4);
        chk("t6_rd_idx36", mem_read_data, full_word(77));
        cpu_read(A_M1);
        chk("t6_rd_idx39_last", mem_read_data, full_word(80));
        chk("t6_err_survives_load", trit_error, 1);

        // 6b: CPU write to a loaded word
        cpu_write(A_0, 18'h00015);
        cpu_read(A_0);
`ifdef MEM_WRITE_PROTECT_EN
        chk("t6b_protected_word", mem_read_data, full_word(0));
        chk("t6b_protect_fault", protect_fault, 1);
`else
        chk("t6b_write_lands", mem_read_data, 18'h00015);
        chk("t6b_no_protect_fault", protect_fault, 0);
`endif

        // Reset clears the sticky flag
        reset = 1'b1;
        #1;
        chk("end_err_cleared", trit_error, 0);
        chk("end_read_data_cleared", mem_read_data, 0);
        tick();
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
